seq_pattern_tx: RTL and testbench
=================================

SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

Interface
REQ-001 Parameter PATTERN, default 7'b1101100: bit pattern transmitted MSB first.
REQ-002 Parameter LEN, default 7: pattern length in bits, legal range 2..16.
REQ-003 Parameter GAP, default 0: idle cycles (seq=0) inserted between consecutive frames, legal range 0..15.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 start  input  1  request to begin a burst; sampled only in IDLE.
REQ-007 nframes  input  4  frame count, latched when start is accepted; 0 = continuous until abort.
REQ-008 abort  input  1  synchronous stop request; takes effect in any state.
REQ-009 seq  output  1  serial pattern output, registered.
REQ-010 busy  output  1  high while a burst is in progress (SEND or GAP).
REQ-011 done  output  1  one-cycle pulse marking normal burst completion.

Function
REQ-012 FSM states SHALL be IDLE, SEND and GAP only.
REQ-013 IDLE: seq=0 and busy=0; start=1 and abort=0 at an edge -> SEND, nframes latched, bit index = LEN-1.
REQ-014 Latency: seq SHALL equal PATTERN[LEN-1] in the cycle immediately after the accepting edge, with busy=1 in the same cycle.
REQ-015 SEND: seq = PATTERN[bit index] for exactly one cycle per bit; the index decrements each edge.
REQ-016 At index 0 with frames remaining and GAP>0 -> GAP; with frames remaining and GAP=0 -> SEND at index LEN-1 (back-to-back, no idle bit).
REQ-017 At index 0 of the last frame -> IDLE; done=1 for exactly the first IDLE cycle.
REQ-018 GAP: seq=0 and busy=1 for exactly GAP cycles, then SEND at index LEN-1.
REQ-019 Frame counter is 4 bits and decrements at the end of each frame; nframes=0 never terminates and the counter SHALL NOT wrap into termination.
REQ-020 abort=1 at any edge -> IDLE on that edge; seq=0, busy=0, no done pulse.
REQ-021 start and abort high on the same IDLE edge: abort wins and the FSM stays in IDLE.
REQ-022 start while busy SHALL be ignored and SHALL NOT relatch nframes.
REQ-023 start held high continuously SHALL begin a new burst on the edge where done is high (IDLE cycle), giving exactly one idle cycle between bursts.
REQ-024 Unreachable state encodings SHALL return to IDLE with seq=0.

Reset
REQ-025 rst=1 SHALL force IDLE, seq=0, busy=0, done=0, and zero the bit index and frame counter, independent of clk.
REQ-026 Reset asserted mid-frame SHALL truncate the frame immediately with no done pulse; the first accepted start after release SHALL begin at PATTERN[LEN-1].

Structure
REQ-027 A shared package SHALL hold the state encoding (IDLE=2'b00, SEND=2'b01, GAP=2'b10) and the default pattern constant 7'b1101100, reused by the matching detector.
REQ-028 The design SHALL be a single module with no sub-modules; bit index and frame counter are internal registers.

Verification
REQ-029 Reset, start=1, nframes=1, GAP=0 -> seq over 7 cycles = 1,1,0,1,1,0,0; busy high for 7 cycles; done high in cycle 8.
REQ-030 nframes=3, GAP=2 -> 1101100 00 1101100 00 1101100, then done; busy high for 25 cycles.
REQ-031 nframes=0, GAP=0 -> continuous 1101100 repeating for 50 frames; abort in frame 50 bit 3 -> seq=0 and busy=0 the next cycle, no done.
REQ-032 start pulsed during frame 1 of a 2-frame burst with nframes=5 -> exactly 2 frames sent; done after 14 cycles.
REQ-033 rst asserted asynchronously mid-cycle during bit 4 -> seq=0 and busy=0 before the next edge; a new start then yields 1101100 from the first bit.
REQ-034 start and abort high together in IDLE -> busy stays 0 and seq stays 0 for 10 cycles.

Source files
------------

// File: rtl/seq_pattern_tx_pkg.sv
// Shared definitions for the serial pattern transmitter and its matching detector:
// state encoding, default pattern constant and a pattern bit-select helper.
package seq_pattern_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SEND = 2'b01,
        ST_GAP  = 2'b10
    } seq_state_e;

    localparam logic [6:0]  DEFAULT_PATTERN = 7'b1101100;
    localparam int unsigned DEFAULT_LEN     = 7;

    // Patterns are carried in a 16-bit container, right-aligned, MSB sent first.
    function automatic logic pattern_bit(input logic [15:0] pattern, input logic [3:0] idx);
        return pattern[idx];
    endfunction

endpackage

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends PATTERN MSB first for a latched number of
// frames (0 = until abort), with GAP idle cycles between frames.
module seq_pattern_tx
    import seq_pattern_tx_pkg::*;
#(
    parameter logic [15:0] PATTERN = {9'b0_0000_0000, DEFAULT_PATTERN},
    parameter int unsigned LEN     = DEFAULT_LEN,
    parameter int unsigned GAP     = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] nframes,
    input  logic       abort,
    output logic       seq,
    output logic       busy,
    output logic       done
);

    localparam logic [3:0] LAST_IDX     = 4'(LEN - 1);
    localparam logic       HAS_GAP      = (GAP != 0);
    localparam logic [3:0] GAP_LAST_IDX = HAS_GAP ? 4'(GAP - 1) : 4'd0;

    seq_state_e state_r;
    seq_state_e state_nx_s;
    logic [3:0] bit_idx_r;
    logic [3:0] bit_idx_nx_s;
    logic [3:0] frame_cnt_r;
    logic [3:0] frame_cnt_nx_s;
    logic [3:0] gap_cnt_r;
    logic [3:0] gap_cnt_nx_s;
    logic       seq_r;
    logic       seq_nx_s;
    logic       busy_r;
    logic       busy_nx_s;
    logic       done_r;
    logic       done_nx_s;
    logic       last_frame_s;

    // A zero frame count means continuous mode: it never reaches 1, so never terminates.
    assign last_frame_s = (frame_cnt_r == 4'd1);

    // Next-state logic plus the output values to be registered on the coming edge.
    always_comb begin
        state_nx_s     = state_r;
        bit_idx_nx_s   = bit_idx_r;
        frame_cnt_nx_s = frame_cnt_r;
        gap_cnt_nx_s   = gap_cnt_r;
        done_nx_s      = 1'b0;

        if (abort) begin
            state_nx_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_nx_s     = ST_SEND;
                        bit_idx_nx_s   = LAST_IDX;
                        frame_cnt_nx_s = nframes;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_SEND: begin
                    if (bit_idx_r != 4'd0) begin
                        bit_idx_nx_s = bit_idx_r - 4'd1;
                    end else if (last_frame_s) begin
                        state_nx_s     = ST_IDLE;
                        frame_cnt_nx_s = 4'd0;
                        done_nx_s      = 1'b1;
                    end else begin
                        if (frame_cnt_r != 4'd0) begin
                            frame_cnt_nx_s = frame_cnt_r - 4'd1;
                        end else begin
                            frame_cnt_nx_s = 4'd0;
                        end
                        if (HAS_GAP) begin
                            state_nx_s   = ST_GAP;
                            gap_cnt_nx_s = GAP_LAST_IDX;
                        end else begin
                            bit_idx_nx_s = LAST_IDX;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_r == 4'd0) begin
                        state_nx_s   = ST_SEND;
                        bit_idx_nx_s = LAST_IDX;
                    end else begin
                        gap_cnt_nx_s = gap_cnt_r - 4'd1;
                    end
                end
                default: begin
                    state_nx_s = ST_IDLE;
                end
            endcase
        end

        if (state_nx_s == ST_SEND) begin
            seq_nx_s  = pattern_bit(PATTERN, bit_idx_nx_s);
            busy_nx_s = 1'b1;
        end else if (state_nx_s == ST_GAP) begin
            seq_nx_s  = 1'b0;
            busy_nx_s = 1'b1;
        end else begin
            seq_nx_s  = 1'b0;
            busy_nx_s = 1'b0;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            bit_idx_r   <= 4'd0;
            frame_cnt_r <= 4'd0;
            gap_cnt_r   <= 4'd0;
            seq_r       <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            bit_idx_r   <= bit_idx_nx_s;
            frame_cnt_r <= frame_cnt_nx_s;
            gap_cnt_r   <= gap_cnt_nx_s;
            seq_r       <= seq_nx_s;
            busy_r      <= busy_nx_s;
            done_r      <= done_nx_s;
        end
    end

    assign seq  = seq_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Scoreboard bench for seq_pattern_tx: two instances (GAP=0 and GAP=2) share stimulus;
// an arithmetic frame/position model predicts {seq,busy,done} for every cycle.
module tb_seq_pattern_tx;

    localparam int LEN = 7;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] nframes;
    logic       abort;
    logic       seq0, busy0, done0;
    logic       seq2, busy2, done2;

    logic [6:0] pat;
    int         gaps [2];
    bit         active [2];
    int         pos [2];
    int         left [2];
    bit         cont [2];

    logic [2:0] exp0 [$];
    logic [2:0] exp2 [$];
    logic [2:0] e0, e2;

    int n_checks;
    int n_pass;

    seq_pattern_tx #(.GAP(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .nframes(nframes), .abort(abort),
        .seq(seq0), .busy(busy0), .done(done0)
    );

    seq_pattern_tx #(.GAP(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start), .nframes(nframes), .abort(abort),
        .seq(seq2), .busy(busy2), .done(done2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check3(input string name, input logic [2:0] act, input logic [2:0] expv);
        n_checks++;
        if (act === expv) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: seq/busy/done got %b expected %b", name, $time, act, expv);
        end
    endtask

    // Model: a burst is a sequence of LEN+gap periods; pos is the position in the current period.
    task automatic model_step(input int k, input bit r, input bit s, input bit a, input logic [3:0] nf);
        logic [2:0] ev;
        int np;
        ev = 3'b000;
        if (r || a) begin
            active[k] = 1'b0;
        end else if (!active[k]) begin
            if (s) begin
                active[k] = 1'b1;
                pos[k]    = 0;
                left[k]   = int'(nf);
                cont[k]   = (nf == 4'd0);
                ev        = {pat[LEN-1], 1'b1, 1'b0};
            end
        end else begin
            np = pos[k] + 1;
            if (np == LEN && !cont[k] && left[k] == 1) begin
                active[k] = 1'b0;
                ev        = 3'b001;
            end else begin
                if (np == LEN + gaps[k]) begin
                    np = 0;
                    left[k]--;
                end
                pos[k] = np;
                ev = {(np < LEN) ? pat[LEN-1-np] : 1'b0, 1'b1, 1'b0};
            end
        end
        if (k == 0) exp0.push_back(ev);
        else        exp2.push_back(ev);
    endtask

    task automatic step(input bit r, input bit s, input bit a, input logic [3:0] nf, input bit mid_chk);
        @(negedge clk);
        rst     = r;
        start   = s;
        abort   = a;
        nframes = nf;
        model_step(0, r, s, a, nf);
        model_step(1, r, s, a, nf);
        if (mid_chk) begin
            #1;
            check3("async_rst_gap0", {seq0, busy0, done0}, 3'b000);
            check3("async_rst_gap2", {seq2, busy2, done2}, 3'b000);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    endtask

    // Monitor: after each rising edge, pop the prediction for that edge and compare.
    always @(posedge clk) begin
        #1;
        if (exp0.size() > 0) begin
            e0 = exp0.pop_front();
            check3("out_gap0", {seq0, busy0, done0}, e0);
        end
        if (exp2.size() > 0) begin
            e2 = exp2.pop_front();
            check3("out_gap2", {seq2, busy2, done2}, e2);
        end
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        pat      = 7'b1101100;
        gaps[0]  = 0;
        gaps[1]  = 2;
        for (int k = 0; k < 2; k++) begin
            active[k] = 1'b0;
            pos[k]    = 0;
            left[k]   = 0;
            cont[k]   = 1'b0;
        end
        rst     = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        nframes = 4'd0;
        #1;
        check3("reset_gap0", {seq0, busy0, done0}, 3'b000);
        check3("reset_gap2", {seq2, busy2, done2}, 3'b000);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);

        // single frame
        step(1'b0, 1'b1, 1'b0, 4'd1, 1'b0);
        idle(10);
        // three frames
        step(1'b0, 1'b1, 1'b0, 4'd3, 1'b0);
        idle(30);
        // continuous, abort in frame 50 bit 3 (GAP=0 instance)
        step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        idle(346);
        step(1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
        idle(3);
        // start while busy must not relatch
        step(1'b0, 1'b1, 1'b0, 4'd2, 1'b0);
        idle(2);
        step(1'b0, 1'b1, 1'b0, 4'd5, 1'b0);
        idle(25);
        // start and abort together in idle
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1, 4'd1, 1'b0);
        idle(2);
        // async reset mid-frame, then restart
        step(1'b0, 1'b1, 1'b0, 4'd1, 1'b0);
        idle(3);
        step(1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 4'd1, 1'b0);
        idle(12);
        // start held high: one idle cycle between bursts
        for (int i = 0; i < 24; i++) step(1'b0, 1'b1, 1'b0, 4'd1, 1'b0);
        idle(12);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            bit r, s, a;
            logic [3:0] nf;
            r  = ($urandom_range(0, 199) == 0);
            a  = ($urandom_range(0, 59) == 0);
            s  = ($urandom_range(0, 3) == 0);
            nf = 4'($urandom_range(0, 4));
            step(r, s, a, nf, r);
        end
        idle(2);

        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (exp0.size() == 0 && exp2.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL drain: pending predictions got %0d expected 0", exp0.size() + exp2.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
